rgmii_tx_ser: RTL

RGMII_TX_SER -- requirements
Module: rgmii_tx_ser

---
 rtl/rgmii_tx_ser_if.sv | 14 +
 rtl/rgmii_tx_ser.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_ser_if.sv
// Streaming word interface into the RGMII transmit serializer.
// The master drives frame words; the slave returns s_ready.
interface rgmii_tx_ser_if #(
    parameter int IN_BYTES = 1
);
    logic [8*IN_BYTES-1:0] s_data;
    logic [IN_BYTES-1:0]   s_keep;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (output s_data, s_keep, s_valid, s_last, input s_ready);
    modport slave  (input s_data, s_keep, s_valid, s_last, output s_ready);
endinterface

// File: rtl/rgmii_tx_ser.sv
// RGMII transmit serializer: word FIFO, preamble/SFD framing, 1G DDR or 10/100 nibble output.
// Optional CRC-32 FCS insertion is compiled in with macro RGMII_TX_FCS_EN.
module rgmii_tx_ser #(
    parameter int IN_BYTES   = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int IFG_BYTES  = 12
) (
    input  logic                eth_txc,
    input  logic                rst,
    input  logic                speed_1g,
    rgmii_tx_ser_if.slave       s,
    output logic [3:0]          txd_p,
    output logic [3:0]          txd_n,
    output logic                txctl_p,
    output logic                txctl_n,
    output logic                busy,
    output logic                underrun
);
    localparam int W  = 8 * IN_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
    localparam int CW = $clog2(IFG_BYTES + 8);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] HALF_L  = (AW+1)'(FIFO_DEPTH / 2);

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA,
`ifdef RGMII_TX_FCS_EN
        FCS,
`endif
        IFG, DRAIN
    } state_e;

    // ---------------- FIFO ----------------
    logic [W-1:0]        mem_data [FIFO_DEPTH];
    logic [IN_BYTES-1:0] mem_keep [FIFO_DEPTH];
    logic                mem_last [FIFO_DEPTH];
    logic [AW:0]         wptr_q, wptr_d, rptr_q, rptr_d, lcnt_q, lcnt_d;
    logic [AW:0]         level;
    logic                full, empty, wr, rd, ready_w;
    logic [W-1:0]        head_data;
    logic [IN_BYTES-1:0] head_keep;
    logic                head_last;

    assign level     = wptr_q - rptr_q;
    assign full      = (level == DEPTH_L);
    assign empty     = (level == '0);
    // Ready depends only on registered pointers and reset, never on s_valid.
    assign ready_w   = ~rst & ~full;
    assign s.s_ready = ready_w;
    assign wr        = s.s_valid & ready_w;
    assign head_data = mem_data[rptr_q[AW-1:0]];
    assign head_keep = mem_keep[rptr_q[AW-1:0]];
    assign head_last = mem_last[rptr_q[AW-1:0]];

    always_ff @(posedge eth_txc) begin
        if (wr) begin
            mem_data[wptr_q[AW-1:0]] <= s.s_data;
            mem_keep[wptr_q[AW-1:0]] <= s.s_keep;
            mem_last[wptr_q[AW-1:0]] <= s.s_last;
        end
    end

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(wr);
        rptr_d = rptr_q + (AW+1)'(rd);
        lcnt_d = lcnt_q;
        case ({wr & s.s_last, rd & head_last})
            2'b10:   lcnt_d = lcnt_q + 1'b1;
            2'b01:   lcnt_d = lcnt_q - 1'b1;
            default: lcnt_d = lcnt_q;
        endcase
    end

    // Index of the final byte of the last word: one below the lowest zero in keep.
    function automatic logic [BW-1:0] last_idx(input logic [IN_BYTES-1:0] k);
        logic [BW-1:0] r;
        r = BW'(IN_BYTES - 1);
        for (int i = IN_BYTES - 1; i >= 0; i--)
            if (!k[i]) r = (i == 0) ? '0 : BW'(i - 1);
        return r;
    endfunction

    // ---------------- framing FSM ----------------
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bidx_q, bidx_d;
    logic            phase_q, phase_d;
    logic            mode1g_q, mode1g_d;
    logic            err_q, err_d;
    logic            urun_q, urun_d;
    logic            byte_done, err_now, word_end;
    logic [7:0]      cur_byte;

    assign byte_done = mode1g_q | phase_q;
    assign err_now   = (state_q == DATA) & (err_q | empty);
    assign word_end  = head_last ? (bidx_q == last_idx(head_keep)) : (bidx_q == BW'(IN_BYTES - 1));
    assign cur_byte  = head_data[8*int'(bidx_q) +: 8];

`ifdef RGMII_TX_FCS_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bidx_d   = bidx_q;
        mode1g_d = mode1g_q;
        err_d    = 1'b0;
        urun_d   = 1'b0;
        rd       = 1'b0;
        // Nibble phase only runs inside byte-timed states so IFG always starts aligned.
        phase_d  = (state_q == IDLE || state_q == DRAIN || mode1g_q) ? 1'b0 : ~phase_q;
`ifdef RGMII_TX_FCS_EN
        crc_d    = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (lcnt_q != '0 || level >= HALF_L) begin
                    state_d  = PRE;
                    cnt_d    = '0;
                    mode1g_d = speed_1g;
                end
            end
            PRE: begin
                if (byte_done) begin
                    if (cnt_q == CW'(6)) begin
                        state_d = SFD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SFD: begin
                bidx_d = '0;
`ifdef RGMII_TX_FCS_EN
                crc_d  = 32'hFFFFFFFF;
`endif
                if (byte_done) state_d = DATA;
            end
            DATA: begin
                if (err_now) begin
                    err_d  = ~byte_done;
                    urun_d = ~err_q;
                    if (byte_done) state_d = DRAIN;
                end else if (byte_done) begin
`ifdef RGMII_TX_FCS_EN
                    crc_d = crc_byte(crc_q, cur_byte);
`endif
                    if (word_end) begin
                        rd     = 1'b1;
                        bidx_d = '0;
                        if (head_last) begin
                            cnt_d = '0;
`ifdef RGMII_TX_FCS_EN
                            state_d = FCS;
`else
                            state_d = IFG;
`endif
                        end
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
`ifdef RGMII_TX_FCS_EN
            FCS: begin
                if (byte_done) begin
                    if (cnt_q == CW'(3)) begin
                        state_d = IFG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            IFG: begin
                if (byte_done) begin
                    if (cnt_q == CW'(IFG_BYTES - 1)) state_d = IDLE;
                    else                            cnt_d   = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!empty) begin
                    rd = 1'b1;
                    if (head_last) begin
                        state_d = IFG;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output encoding ----------------
    logic [7:0] byte_v;
    logic [3:0] nib, txd_p_d, txd_n_d;
    logic       en_v, er_v, txctl_p_d, txctl_n_d;

    always_comb begin
        byte_v = 8'h00;
        en_v   = 1'b0;
        er_v   = 1'b0;
        case (state_q)
            PRE:  begin byte_v = 8'h55; en_v = 1'b1; end
            SFD:  begin byte_v = 8'hD5; en_v = 1'b1; end
            DATA: begin
                en_v = 1'b1;
                if (err_now) er_v   = 1'b1;
                else         byte_v = cur_byte;
            end
`ifdef RGMII_TX_FCS_EN
            FCS:  begin byte_v = ~crc_q[{cnt_q[1:0], 3'b000} +: 8]; en_v = 1'b1; end
`endif
            default: ;
        endcase
        nib       = phase_q ? byte_v[7:4] : byte_v[3:0];
        txd_p_d   = mode1g_q ? byte_v[3:0] : nib;
        txd_n_d   = mode1g_q ? byte_v[7:4] : nib;
        txctl_p_d = en_v;
        txctl_n_d = en_v ^ er_v;
    end

    always_ff @(posedge eth_txc) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            lcnt_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bidx_q   <= '0;
            phase_q  <= 1'b0;
            mode1g_q <= 1'b0;
            err_q    <= 1'b0;
            urun_q   <= 1'b0;
            txd_p    <= '0;
            txd_n    <= '0;
            txctl_p  <= 1'b0;
            txctl_n  <= 1'b0;
`ifdef RGMII_TX_FCS_EN
            crc_q    <= 32'hFFFFFFFF;
`endif
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            lcnt_q   <= lcnt_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            phase_q  <= phase_d;
            mode1g_q <= mode1g_d;
            err_q    <= err_d;
            urun_q   <= urun_d;
            txd_p    <= txd_p_d;
            txd_n    <= txd_n_d;
            txctl_p  <= txctl_p_d;
            txctl_n  <= txctl_n_d;
`ifdef RGMII_TX_FCS_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign underrun = urun_q;
endmodule
